instr_fetch: RTL and testbench

Instruction fetch stage feeding the processor's decode stage. Maintains the program counter, issues single-outstanding word reads to instruction memory, and buffers fetched words with their addresses in a small prefetch queue. Presents them to decode over a valid/ready handshake. Handles branch redirects (flush plus squash of in-flight data) and halt.

---
 rtl/instr_fetch.sv | 167 ++++++++++++++++
 tb/tb_instr_fetch.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC, single-outstanding memory reads, prefetch queue to decode.
// Optional macro FETCH_PREDECODE_HALT_EN stops fetch on an enqueued HALT word (bits [31:28]=4'b1000).
module instr_fetch #(
    parameter int unsigned       ADDR_W   = 12,
    parameter int unsigned       DEPTH    = 2,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata,
    output logic [31:0]       instr,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              instr_valid,
    input  logic              instr_ready,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_addr,
    input  logic              halt,
    output logic              halted
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = $clog2(DEPTH + 1);
    localparam logic [PtrW-1:0] LastPtr = PtrW'(DEPTH - 1);
    localparam logic [CntW-1:0] DepthC  = CntW'(DEPTH);

    typedef enum logic [1:0] {StFetch, StWait, StStop} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] req_addr_q, req_addr_d;
    logic              squash_q, squash_d;
    logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CntW-1:0]   count_q, count_d;
    logic [31:0]       q_data_q [DEPTH];
    logic [ADDR_W-1:0] q_pc_q   [DEPTH];

    logic              issue;
    logic              ack_fire;
    logic              enq;
    logic              deq;
    logic              pd_halt;
    logic [ADDR_W-1:0] cur_addr;

    assign instr_valid = (count_q != '0);
    assign instr       = q_data_q[rd_ptr_q];
    assign instr_pc    = q_pc_q[rd_ptr_q];
    assign halted      = (state_q == StStop);

    // While waiting, the address of the outstanding request is held even if a redirect moved the PC.
    always_comb begin
        cur_addr = (state_q == StWait) ? req_addr_q : pc_q;
        issue    = !reset && (state_q == StFetch) && (count_q < DepthC) && !halt;
        mem_req  = issue || (!reset && (state_q == StWait));
        mem_addr = mem_req ? cur_addr : '0;
        ack_fire = mem_req && mem_ack;
        enq      = ack_fire && !squash_q && !redirect;
        deq      = instr_valid && instr_ready;
    end

`ifdef FETCH_PREDECODE_HALT_EN
    assign pd_halt = enq && (mem_rdata[31:28] == 4'b1000);
`else
    assign pd_halt = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        req_addr_d = req_addr_q;
        squash_d   = squash_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;

        if (enq) begin
            pc_d = cur_addr + 1'b1;
        end
        if (redirect) begin
            pc_d = redirect_addr;
        end

        // A request left un-acked becomes outstanding; a redirect now marks its data as stale.
        if (mem_req && !mem_ack) begin
            req_addr_d = cur_addr;
            if (redirect) begin
                squash_d = 1'b1;
            end
        end
        if (ack_fire) begin
            squash_d = 1'b0;
        end

        unique case (state_q)
            StFetch: begin
                if (halt || pd_halt) begin
                    state_d = StStop;
                end else if (issue && !mem_ack) begin
                    state_d = StWait;
                end
            end
            StWait: begin
                if (mem_ack) begin
                    state_d = (halt || pd_halt) ? StStop : StFetch;
                end
            end
            StStop: begin
                if (redirect && !halt) begin
                    state_d = StFetch;
                end
            end
            default: state_d = StFetch;
        endcase

        if (redirect) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (enq) begin
                wr_ptr_d = (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + 1'b1;
            end
            if (deq) begin
                rd_ptr_d = (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + 1'b1;
            end
            if (enq && !deq) begin
                count_d = count_q + 1'b1;
            end else if (!enq && deq) begin
                count_d = count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StFetch;
            pc_q       <= RESET_PC;
            req_addr_q <= '0;
            squash_q   <= 1'b0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_addr_q <= req_addr_d;
            squash_q   <= squash_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            q_data_q <= '{default: '0};
            q_pc_q   <= '{default: '0};
        end else if (enq) begin
            q_data_q[wr_ptr_q] <= mem_rdata;
            q_pc_q[wr_ptr_q]   <= cur_addr;
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: vector table for streaming/backpressure,
// hand sequences for redirect squash, PC wrap, halt and HALT-word predecode.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_req;
    logic [11:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic [31:0] instr;
    logic [11:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        redirect;
    logic [11:0] redirect_addr;
    logic        halt;
    logic        halted;

    int n_checks = 0;
    int n_fail   = 0;
    int lat      = 0;
    int wait_cnt = 0;

    always #5 clk = ~clk;

    instr_fetch #(
        .ADDR_W  (12),
        .DEPTH   (2),
        .RESET_PC(12'h010)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .mem_req      (mem_req),
        .mem_addr     (mem_addr),
        .mem_ack      (mem_ack),
        .mem_rdata    (mem_rdata),
        .instr        (instr),
        .instr_pc     (instr_pc),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .redirect     (redirect),
        .redirect_addr(redirect_addr),
        .halt         (halt),
        .halted       (halted)
    );

    // Memory model: word 0x003 holds a HALT opcode, all others encode their address.
    function automatic logic [31:0] word_at(input logic [11:0] a);
        return (a == 12'h003) ? 32'h8000_0000 : {20'h10000, a};
    endfunction

    assign mem_ack   = mem_req && (wait_cnt >= lat);
    assign mem_rdata = mem_req ? word_at(mem_addr) : 32'h0;

    always @(posedge clk) begin
        if (reset || !mem_req || mem_ack) wait_cnt <= 0;
        else                              wait_cnt <= wait_cnt + 1;
    end

    typedef struct packed {
        logic        rdy;
        logic        req;
        logic [11:0] addr;
        logic        valid;
        logic [11:0] pc;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int l);
        reset         = 1'b1;
        redirect      = 1'b0;
        redirect_addr = 12'h0;
        halt          = 1'b0;
        instr_ready   = 1'b1;
        lat           = l;
        tick();
        tick();
        @(negedge clk);
        chk("rst_mem_req", 32'(mem_req), 32'h0);
        chk("rst_mem_addr", 32'(mem_addr), 32'h0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_instr_pc", 32'(instr_pc), 32'h0);
        chk("rst_valid", 32'(instr_valid), 32'h0);
        chk("rst_halted", 32'(halted), 32'h0);
        tick();
        reset = 1'b0;
    endtask

    initial begin
        vecs[0] = '{1'b1, 1'b1, 12'h010, 1'b0, 12'h000};
        vecs[1] = '{1'b1, 1'b1, 12'h011, 1'b1, 12'h010};
        vecs[2] = '{1'b1, 1'b1, 12'h012, 1'b1, 12'h011};
        vecs[3] = '{1'b0, 1'b1, 12'h013, 1'b1, 12'h012};
        vecs[4] = '{1'b0, 1'b0, 12'h000, 1'b1, 12'h012};
        vecs[5] = '{1'b0, 1'b0, 12'h000, 1'b1, 12'h012};
        vecs[6] = '{1'b1, 1'b0, 12'h000, 1'b1, 12'h012};
        vecs[7] = '{1'b1, 1'b1, 12'h014, 1'b1, 12'h013};
        vecs[8] = '{1'b1, 1'b1, 12'h015, 1'b1, 12'h014};

        // Zero-wait streaming from RESET_PC, then decode backpressure with a full queue.
        do_reset(0);
        for (int i = 0; i < 9; i++) begin
            instr_ready = vecs[i].rdy;
            @(negedge clk);
            chk($sformatf("vec%0d_req", i), 32'(mem_req), 32'(vecs[i].req));
            if (vecs[i].req) chk($sformatf("vec%0d_addr", i), 32'(mem_addr), 32'(vecs[i].addr));
            chk($sformatf("vec%0d_valid", i), 32'(instr_valid), 32'(vecs[i].valid));
            if (vecs[i].valid) begin
                chk($sformatf("vec%0d_pc", i), 32'(instr_pc), 32'(vecs[i].pc));
                chk($sformatf("vec%0d_instr", i), instr, word_at(vecs[i].pc));
            end
            tick();
        end

        // Redirect to 0x200 while the read of 0x005 is outstanding: its data must be dropped.
        do_reset(0);
        redirect = 1'b1; redirect_addr = 12'h005;
        tick();
        redirect = 1'b0; lat = 3;
        @(negedge clk);
        chk("rd_c1_addr", 32'(mem_addr), 32'h005);
        chk("rd_c1_valid", 32'(instr_valid), 32'h0);
        tick();
        redirect = 1'b1; redirect_addr = 12'h200;
        @(negedge clk);
        chk("rd_c2_addr", 32'(mem_addr), 32'h005);
        tick();
        redirect = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("rd_hold_req", 32'(mem_req), 32'h1);
            chk("rd_hold_addr", 32'(mem_addr), 32'h005);
            chk("rd_hold_valid", 32'(instr_valid), 32'h0);
            tick();
        end
        lat = 0;
        @(negedge clk);
        chk("rd_tgt_req", 32'(mem_req), 32'h1);
        chk("rd_tgt_addr", 32'(mem_addr), 32'h200);
        chk("rd_tgt_valid", 32'(instr_valid), 32'h0);
        tick();
        @(negedge clk);
        chk("rd_tgt_pc", 32'(instr_pc), 32'h200);
        chk("rd_tgt_instr", instr, 32'h1000_0200);
        tick();

        // PC wraps from 0xFFF to 0x000.
        do_reset(0);
        redirect = 1'b1; redirect_addr = 12'hFFF;
        tick();
        redirect = 1'b0;
        @(negedge clk);
        chk("wrap_addr_fff", 32'(mem_addr), 32'hFFF);
        tick();
        @(negedge clk);
        chk("wrap_addr_000", 32'(mem_addr), 32'h000);
        chk("wrap_pc_fff", 32'(instr_pc), 32'hFFF);
        tick();
        @(negedge clk);
        chk("wrap_pc_000", 32'(instr_pc), 32'h000);
        tick();

        // Halt raised while a request waits: it completes, then fetch stops until a redirect.
        do_reset(2);
        instr_ready = 1'b0;
        tick();
        halt = 1'b1;
        @(negedge clk);
        chk("hw_c1_req", 32'(mem_req), 32'h1);
        chk("hw_c1_halted", 32'(halted), 32'h0);
        tick();
        @(negedge clk);
        chk("hw_ack", 32'(mem_ack), 32'h1);
        chk("hw_c2_halted", 32'(halted), 32'h0);
        tick();
        for (int i = 0; i < 4; i++) begin
            if (i == 3) halt = 1'b0;
            @(negedge clk);
            chk("hw_stop_halted", 32'(halted), 32'h1);
            chk("hw_stop_req", 32'(mem_req), 32'h0);
            chk("hw_stop_pc", 32'(instr_pc), 32'h010);
            tick();
        end
        redirect = 1'b1; redirect_addr = 12'h080;
        @(negedge clk);
        chk("hw_redir_halted", 32'(halted), 32'h1);
        tick();
        redirect = 1'b0;
        @(negedge clk);
        chk("hw_resume_halted", 32'(halted), 32'h0);
        chk("hw_resume_req", 32'(mem_req), 32'h1);
        chk("hw_resume_addr", 32'(mem_addr), 32'h080);
        chk("hw_resume_valid", 32'(instr_valid), 32'h0);
        tick();

        // Halt while idle: no request, halted the next cycle.
        do_reset(0);
        halt = 1'b1;
        @(negedge clk);
        chk("hi_req", 32'(mem_req), 32'h0);
        chk("hi_halted0", 32'(halted), 32'h0);
        tick();
        @(negedge clk);
        chk("hi_halted1", 32'(halted), 32'h1);
        tick();

        // HALT word at 0x003.
        do_reset(0);
        redirect = 1'b1; redirect_addr = 12'h001;
        tick();
        redirect = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            chk("pd_addr", 32'(mem_addr), 32'(i));
            tick();
        end
        @(negedge clk);
        chk("pd_pc", 32'(instr_pc), 32'h003);
        chk("pd_instr", instr, 32'h8000_0000);
`ifdef FETCH_PREDECODE_HALT_EN
        chk("pd_halted", 32'(halted), 32'h1);
        chk("pd_req", 32'(mem_req), 32'h0);
        tick();
        @(negedge clk);
        chk("pd_req_after", 32'(mem_req), 32'h0);
`else
        chk("pd_halted", 32'(halted), 32'h0);
        chk("pd_req", 32'(mem_req), 32'h1);
        chk("pd_addr_004", 32'(mem_addr), 32'h004);
`endif
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
